if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_buf.sv | 80 ++++++++
 rtl/if_fetch_stage.sv | 131 +++++++++++++
 tb/tb_if_fetch_stage.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the instruction-fetch slice.
//   WORD_W        : architectural word width (32)
//   RESET_PC      : default first fetch address after reset
//   NOP_WORD      : default bubble instruction driven when no valid fetch
//   fetch_state_t : fetch FSM encoding (REQ / WAIT / DROP)
package cpu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [WORD_W-1:0] RESET_PC = 32'h0040_0000;
  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  // FS_REQ  : request may be presented to instruction memory
  // FS_WAIT : one request granted, response not yet returned
  // FS_DROP : one request outstanding whose response must be discarded
  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_DROP = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry fetch buffer: an output register facing the IF/ID register
// plus one skid entry that absorbs a response arriving while the output
// is stalled.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   push              : write {push_instr, push_pc} into the buffer
//   pop               : output entry consumed downstream this cycle
//   clear             : flush both entries (redirect)
//   out_valid         : output entry holds a live instruction
//   out_instr/out_pc  : output entry contents
//   out_pc_plus4      : out_pc + 4, captured together with out_pc
//   skid_full         : skid entry occupied
module fetch_buf #(
  parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        push,
  input  logic [31:0] push_instr,
  input  logic [31:0] push_pc,
  input  logic        pop,
  input  logic        clear,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4,
  output logic        skid_full
);

  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        out_free;

  // The output slot can take new data when empty or drained this cycle.
  assign out_free = ~out_valid | pop;

  // Output entry: fully reset, because its contents are visible ports
  // with defined reset values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      skid_full    <= 1'b0;
      out_instr    <= NOP_WORD;
      out_pc       <= '0;
      out_pc_plus4 <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      skid_full <= 1'b0;
      out_instr <= NOP_WORD;
    end else if (pop && skid_full) begin
      // Skid advances into the output; a simultaneous push refills skid.
      out_valid    <= 1'b1;
      out_instr    <= skid_instr;
      out_pc       <= skid_pc;
      out_pc_plus4 <= skid_pc + 32'd4;
      skid_full    <= push;
    end else if (push && out_free) begin
      out_valid    <= 1'b1;
      out_instr    <= push_instr;
      out_pc       <= push_pc;
      out_pc_plus4 <= push_pc + 32'd4;
    end else if (push) begin
      skid_full <= 1'b1;
    end else if (pop) begin
      // Drained with nothing behind it: present a bubble.
      out_valid <= 1'b0;
      out_instr <= NOP_WORD;
    end
  end

  // Skid payload is only meaningful while skid_full is set, so it needs
  // no reset.
  always_ff @(posedge clk) begin
    if (push && !(out_free && !(pop && skid_full))) begin
      skid_instr <= push_instr;
      skid_pc    <= push_pc;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage. Keeps the PC, issues at most one outstanding
// instruction-memory request, and hands fetched words to the IF/ID
// register through a two-entry buffer. Redirects flush the buffer and
// mark any in-flight response as stale.
// Ports:
//   clk, reset                      : clock, asynchronous active-low reset
//   stall                           : IF/ID not accepting this cycle
//   redirect, redirect_pc           : control-flow redirect and target
//   imem_req, imem_addr             : memory request and address (= PC)
//   imem_gnt                        : request accepted
//   imem_rvalid, imem_rdata         : memory response
//   if_valid, if_instruction,
//   if_pc, if_pc_plus4              : fetched instruction to IF/ID
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
  parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4
);

  import cpu_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  inflight_pc_q;
  logic         started_q;
  logic         load_inflight;
  logic         buf_push;
  logic         buf_pop;
  logic         skid_full;

  // started_q keeps imem_req low during reset and lets it rise on the
  // first edge after release. A full skid means there is nowhere to put
  // another response, so no new request is issued.
  assign imem_req  = started_q && (state_q == FS_REQ) && !skid_full;
  assign imem_addr = pc_q;
  assign buf_pop   = if_valid && !stall;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    load_inflight = 1'b0;
    buf_push      = 1'b0;
    case (state_q)
      FS_REQ: begin
        if (redirect) begin
          // An ungranted request is simply abandoned; a granted one
          // leaves a response that must be dropped.
          pc_d = redirect_pc;
          if (imem_req && imem_gnt) state_d = FS_DROP;
        end else if (imem_req && imem_gnt) begin
          load_inflight = 1'b1;
          pc_d          = pc_q + 32'd4;
          state_d       = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          state_d = imem_rvalid ? FS_REQ : FS_DROP;
        end else if (imem_rvalid) begin
          buf_push = 1'b1;
          state_d  = FS_REQ;
        end
      end
      FS_DROP: begin
        // The stale response is discarded; further redirects only move
        // the PC while it is still pending.
        if (redirect) pc_d = redirect_pc;
        if (imem_rvalid) state_d = FS_REQ;
      end
      default: state_d = FS_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= FS_REQ;
      pc_q      <= RESET_PC;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      started_q <= 1'b1;
    end
  end

  // Address of the outstanding request; only read when its response
  // returns, so it carries no reset.
  always_ff @(posedge clk) begin
    if (load_inflight) inflight_pc_q <= pc_q;
  end

  // Response boundary: fetched word enters the output/skid buffer.
  fetch_buf #(
    .NOP_WORD(NOP_WORD)
  ) u_fetch_buf (
    .clk          (clk),
    .reset        (reset),
    .push         (buf_push),
    .push_instr   (imem_rdata),
    .push_pc      (inflight_pc_q),
    .pop          (buf_pop),
    .clear        (redirect),
    .out_valid    (if_valid),
    .out_instr    (if_instruction),
    .out_pc       (if_pc),
    .out_pc_plus4 (if_pc_plus4),
    .skid_full    (skid_full)
  );

  // A response with nothing outstanding breaks the memory protocol.
  a_no_rvalid_in_req: assert property (
    @(posedge clk) disable iff (!reset)
    !(state_q == FS_REQ && imem_rvalid)
  );

endmodule

// File: tb/tb_if_fetch_stage.sv
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instruction;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;

  int checks = 0;
  int errors = 0;

  // Memory model controls
  logic        gnt_en;
  logic        mem_en;
  logic        resp_pending;
  logic [31:0] resp_addr;
  logic        force_en;
  logic [31:0] force_data;

  if_fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_instruction (if_instruction),
    .if_pc          (if_pc),
    .if_pc_plus4    (if_pc_plus4)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: memory inputs driven at the falling edge, outputs
  // observed 1 time unit after the rising edge.
  task automatic step();
    logic grant_now;
    logic [31:0] grant_addr;
    @(negedge clk);
    imem_rvalid = resp_pending && mem_en;
    imem_rdata  = force_en ? force_data : word_of(resp_addr);
    imem_gnt    = gnt_en;
    grant_now   = imem_req && imem_gnt;
    grant_addr  = imem_addr;
    @(posedge clk);
    #1;
    if (imem_rvalid) begin
      resp_pending = 1'b0;
      force_en     = 1'b0;
    end
    if (grant_now) begin
      resp_pending = 1'b1;
      resp_addr    = grant_addr;
    end
  endtask

  initial begin
    reset        = 1'b0;
    stall        = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    imem_gnt     = 1'b0;
    imem_rvalid  = 1'b0;
    imem_rdata   = '0;
    gnt_en       = 1'b1;
    mem_en       = 1'b1;
    resp_pending = 1'b0;
    resp_addr    = '0;
    force_en     = 1'b0;
    force_data   = '0;

    // Reset state
    @(posedge clk); #1;
    check("rst_req",   {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, if_valid}, 32'd0);
    check("rst_instr", if_instruction, 32'h0000_0000);
    check("rst_pc",    if_pc, 32'h0);
    check("rst_pc4",   if_pc_plus4, 32'h0);
    check("rst_addr",  imem_addr, 32'h0040_0000);

    reset = 1'b1;
    step();
    check("first_req",  {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0040_0000);

    // Streaming: one instruction every two cycles
    for (int i = 0; i < 4; i++) begin
      step();
      check("str_bubble", {31'd0, if_valid}, 32'd0);
      check("str_addr", imem_addr, 32'h0040_0000 + 32'(4 * (i + 1)));
      step();
      check("str_valid", {31'd0, if_valid}, 32'd1);
      check("str_pc",    if_pc, 32'h0040_0000 + 32'(4 * i));
      check("str_pc4",   if_pc_plus4, 32'h0040_0004 + 32'(4 * i));
      check("str_instr", if_instruction, word_of(32'h0040_0000 + 32'(4 * i)));
    end

    // Stall for 5 cycles holding 0x0040000C; 0x00400010 lands in skid
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stl_valid", {31'd0, if_valid}, 32'd1);
      check("stl_pc",    if_pc, 32'h0040_000C);
      check("stl_instr", if_instruction, word_of(32'h0040_000C));
      if (i >= 1) check("stl_noreq", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("skid_valid", {31'd0, if_valid}, 32'd1);
    check("skid_pc",    if_pc, 32'h0040_0010);
    check("skid_instr", if_instruction, word_of(32'h0040_0010));
    check("skid_req",   {31'd0, imem_req}, 32'd1);
    step();
    check("skid_nodup", {31'd0, if_valid}, 32'd0);
    step();
    check("post_pc",    if_pc, 32'h0040_0014);
    check("post_instr", if_instruction, word_of(32'h0040_0014));

    // Redirect while waiting; the late response 0xDEADBEEF is dropped
    step();
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0100;
    mem_en      = 1'b0;
    step();
    check("rdw_valid", {31'd0, if_valid}, 32'd0);
    check("rdw_req",   {31'd0, imem_req}, 32'd0);
    check("rdw_addr",  imem_addr, 32'h0040_0100);
    redirect   = 1'b0;
    mem_en     = 1'b1;
    force_en   = 1'b1;
    force_data = 32'hDEAD_BEEF;
    step();
    check("drop_valid", {31'd0, if_valid}, 32'd0);
    check("drop_instr", if_instruction, 32'h0000_0000);
    check("drop_req",   {31'd0, imem_req}, 32'd1);
    check("drop_addr",  imem_addr, 32'h0040_0100);
    step();
    check("drop_instr2", if_instruction, 32'h0000_0000);
    step();
    check("tgt_valid", {31'd0, if_valid}, 32'd1);
    check("tgt_pc",    if_pc, 32'h0040_0100);
    check("tgt_instr", if_instruction, word_of(32'h0040_0100));

    // Redirect beats stall, while a request is also being granted
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    step();
    check("rs_valid", {31'd0, if_valid}, 32'd0);
    check("rs_instr", if_instruction, 32'h0000_0000);
    check("rs_addr",  imem_addr, 32'hFFFF_FFFC);
    check("rs_req",   {31'd0, imem_req}, 32'd0);
    stall    = 1'b0;
    redirect = 1'b0;
    step();
    check("rs_req2", {31'd0, imem_req}, 32'd1);
    check("rs_valid2", {31'd0, if_valid}, 32'd0);

    // PC wrap
    step();
    check("wrap_addr", imem_addr, 32'h0000_0000);
    step();
    check("wrap_pc",  if_pc, 32'hFFFF_FFFC);
    check("wrap_pc4", if_pc_plus4, 32'h0000_0000);
    check("wrap_instr", if_instruction, word_of(32'hFFFF_FFFC));

    // Ungranted request: address stable, then abandoned on redirect
    gnt_en = 1'b0;
    step();
    check("ng_req",   {31'd0, imem_req}, 32'd1);
    check("ng_addr",  imem_addr, 32'h0000_0000);
    check("ng_valid", {31'd0, if_valid}, 32'd0);
    step();
    check("ng_addr2", imem_addr, 32'h0000_0000);
    redirect    = 1'b1;
    redirect_pc = 32'h0040_0200;
    step();
    check("ng_rreq",  {31'd0, imem_req}, 32'd1);
    check("ng_raddr", imem_addr, 32'h0040_0200);
    redirect = 1'b0;
    gnt_en   = 1'b1;
    step();
    step();
    check("ng_pc", if_pc, 32'h0040_0200);
    stall = 1'b1;
    step();
    check("pre_rst_valid", {31'd0, if_valid}, 32'd1);
    check("pre_rst_req",   {31'd0, imem_req}, 32'd0);

    // Asynchronous reset while a request is outstanding
    #2;
    reset        = 1'b0;
    resp_pending = 1'b0;
    stall        = 1'b0;
    #1;
    check("arst_req",   {31'd0, imem_req}, 32'd0);
    check("arst_valid", {31'd0, if_valid}, 32'd0);
    check("arst_instr", if_instruction, 32'h0000_0000);
    check("arst_pc",    if_pc, 32'h0);
    check("arst_pc4",   if_pc_plus4, 32'h0);
    check("arst_addr",  imem_addr, 32'h0040_0000);
    step();
    reset = 1'b1;
    step();
    check("rs2_req",  {31'd0, imem_req}, 32'd1);
    check("rs2_addr", imem_addr, 32'h0040_0000);
    step();
    step();
    check("rs2_valid", {31'd0, if_valid}, 32'd1);
    check("rs2_pc",    if_pc, 32'h0040_0000);
    check("rs2_instr", if_instruction, word_of(32'h0040_0000));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
